// File: rtl/button_event_ctrl.sv
// button_event_ctrl: debounce and event controller for N synchronized push-buttons.
// Turns stable levels into PRESS/RELEASE/LONG(/REPEAT) events on one valid/ready port.
// Optional feature macro: AUTO_REPEAT_EN (REPEAT events every REPEAT_CYCLES after LONG).
// Ports: clk, rst_n (async active-low), btn_sync[N_BTN] in, btn_level[N_BTN] out,
//   evt_valid/evt_ready handshake, evt_id[2:0], evt_type[1:0], evt_overrun pulse.
module button_event_ctrl #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_sync,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [2:0]       evt_id,
    output logic [1:0]       evt_type,
    output logic             evt_overrun
);

    localparam int MAXA = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int MAXP = (MAXA > REPEAT_CYCLES) ? MAXA : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    // Event type codes double as the bit index into each button's pending nibble.
    localparam logic [1:0] T_PRESS = 2'd0;
    localparam logic [1:0] T_REL   = 2'd1;
    localparam logic [1:0] T_LONG  = 2'd2;
    localparam logic [1:0] T_REP   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE, S_PRESS_WAIT, S_DOWN, S_RELEASE_WAIT
    } state_e;

    state_e                  st_q   [N_BTN];
    state_e                  st_d   [N_BTN];
    logic [CW-1:0]           deb_q  [N_BTN];
    logic [CW-1:0]           deb_d  [N_BTN];
    logic [CW-1:0]           hold_q [N_BTN];
    logic [CW-1:0]           hold_d [N_BTN];
    logic [CW-1:0]           rep_q  [N_BTN];
    logic [CW-1:0]           rep_d  [N_BTN];
    logic [N_BTN-1:0]        lvl_q, lvl_d;
    logic [N_BTN-1:0][3:0]   pend_q, pend_d, set_b, pick, clr;
    logic                    valid_q, valid_d;
    logic [2:0]              id_q, id_d, pid;
    logic [1:0]              type_q, type_d, ptype;
    logic                    ovr_q, ovr_d;
    logic                    free;

    // Per-button debounce / hold FSMs.
    always_comb begin
        st_d   = st_q;
        deb_d  = deb_q;
        hold_d = hold_q;
        rep_d  = rep_q;
        lvl_d  = lvl_q;
        set_b  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            unique case (st_q[i])
                S_IDLE: begin
                    if (btn_sync[i]) begin
                        st_d[i]  = S_PRESS_WAIT;
                        deb_d[i] = '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!btn_sync[i]) begin
                        st_d[i] = S_IDLE;
                    end else if (deb_q[i] == DEB_LAST) begin
                        st_d[i]           = S_DOWN;
                        lvl_d[i]          = 1'b1;
                        set_b[i][T_PRESS] = 1'b1;
                        hold_d[i]         = '0;
                        rep_d[i]          = '0;
                    end else begin
                        deb_d[i] = deb_q[i] + ONE;
                    end
                end
                S_DOWN: begin
                    if (!btn_sync[i]) begin
                        st_d[i]  = S_RELEASE_WAIT;
                        deb_d[i] = '0;
                    end else if (hold_q[i] != LONG_MAX) begin
                        // Hold saturates at LONG_MAX, so LONG fires once per press.
                        hold_d[i] = hold_q[i] + ONE;
                        if (hold_q[i] == LONG_LAST) begin
                            set_b[i][T_LONG] = 1'b1;
                        end
                    end
`ifdef AUTO_REPEAT_EN
                    else if (rep_q[i] == REP_LAST) begin
                        rep_d[i]        = '0;
                        set_b[i][T_REP] = 1'b1;
                    end else begin
                        rep_d[i] = rep_q[i] + ONE;
                    end
`endif
                end
                S_RELEASE_WAIT: begin
                    if (btn_sync[i]) begin
                        st_d[i] = S_DOWN;
                    end else if (deb_q[i] == DEB_LAST) begin
                        st_d[i]         = S_IDLE;
                        lvl_d[i]        = 1'b0;
                        set_b[i][T_REL] = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + ONE;
                    end
                end
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    // Arbiter: descending scan so the lowest pending button overwrites the pick.
    always_comb begin
        pick  = '0;
        pid   = '0;
        ptype = T_PRESS;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (|pend_q[i]) begin
                pick = '0;
                pid  = 3'(i);
                if (pend_q[i][T_PRESS]) begin
                    pick[i][T_PRESS] = 1'b1;
                    ptype            = T_PRESS;
                end else if (pend_q[i][T_LONG]) begin
                    pick[i][T_LONG] = 1'b1;
                    ptype           = T_LONG;
                end else if (pend_q[i][T_REP]) begin
                    pick[i][T_REP] = 1'b1;
                    ptype          = T_REP;
                end else begin
                    pick[i][T_REL] = 1'b1;
                    ptype          = T_REL;
                end
            end
        end
    end

    always_comb begin
        free    = !valid_q || evt_ready;
        clr     = free ? pick : '0;
        valid_d = free ? (|pick) : valid_q;
        id_d    = (free && (|pick)) ? pid : id_q;
        type_d  = (free && (|pick)) ? ptype : type_q;
        // Set wins over clear; a set onto a bit that stays pending is a lost event.
        pend_d  = (pend_q & ~clr) | set_b;
        ovr_d   = |(set_b & pend_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]   <= S_IDLE;
                deb_q[i]  <= '0;
                hold_q[i] <= '0;
                rep_q[i]  <= '0;
            end
            lvl_q   <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            type_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                st_q[i]   <= st_d[i];
                deb_q[i]  <= deb_d[i];
                hold_q[i] <= hold_d[i];
                rep_q[i]  <= rep_d[i];
            end
            lvl_q   <= lvl_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            type_q  <= type_d;
            ovr_q   <= ovr_d;
        end
    end

    assign btn_level   = lvl_q;
    assign evt_valid   = valid_q;
    assign evt_id      = id_q;
    assign evt_type    = type_q;
    assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Testbench for button_event_ctrl: directed scenarios plus random buttons/ready,
// checked every cycle against an event-level reference model.
module tb_button_event_ctrl;

    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int LNG = 16;
    localparam int REP = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_sync = '0;
    logic [N-1:0] btn_level;
    logic         evt_valid;
    logic         evt_ready = 1'b1;
    logic [2:0]   evt_id;
    logic [1:0]   evt_type;
    logic         evt_overrun;

    button_event_ctrl #(
        .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_sync(btn_sync), .btn_level(btn_level),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_type(evt_type), .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: run = consecutive samples differing from the debounced
    // level; hold = samples held high while settled down since the last press.
    int run  [N];
    int hold [N];
    bit lvl  [N];
    bit pend [N][4];
    bit m_valid;
    int m_id, m_type;
    bit m_ovr;
    int prio [4] = '{0, 2, 3, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < N; b++) begin
            run[b] = 0; hold[b] = 0; lvl[b] = 0;
            for (int t = 0; t < 4; t++) pend[b][t] = 0;
        end
        m_valid = 0; m_id = 0; m_type = 0; m_ovr = 0;
    endtask

    task automatic model_tick();
        bit setv [N][4];
        bit clrv [N][4];
        bit found;
        bit ovr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int b = 0; b < N; b++)
            for (int t = 0; t < 4; t++) begin setv[b][t] = 0; clrv[b][t] = 0; end
        found = 0;
        if (!m_valid || evt_ready) begin
            for (int b = 0; b < N; b++)
                for (int k = 0; k < 4; k++)
                    if (!found && pend[b][prio[k]]) begin
                        found = 1; clrv[b][prio[k]] = 1; m_id = b; m_type = prio[k];
                    end
            m_valid = found;
        end
        for (int b = 0; b < N; b++) begin
            if (btn_sync[b] != lvl[b]) begin
                run[b]++;
                if (run[b] == DEB + 1) begin
                    lvl[b] = btn_sync[b];
                    run[b] = 0;
                    if (lvl[b]) begin setv[b][0] = 1; hold[b] = 0; end
                    else setv[b][1] = 1;
                end
            end else begin
                if (lvl[b] && run[b] == 0) begin
                    hold[b]++;
                    if (hold[b] == LNG) setv[b][2] = 1;
                    if (REP_EN && hold[b] > LNG && (hold[b] - LNG) % REP == 0) setv[b][3] = 1;
                end
                run[b] = 0;
            end
        end
        ovr = 0;
        for (int b = 0; b < N; b++)
            for (int t = 0; t < 4; t++) begin
                if (setv[b][t] && pend[b][t] && !clrv[b][t]) ovr = 1;
                pend[b][t] = (pend[b][t] && !clrv[b][t]) || setv[b][t];
            end
        m_ovr = ovr;
    endtask

    task automatic compare();
        for (int b = 0; b < N; b++)
            chk($sformatf("btn_level[%0d]", b), 32'(btn_level[b]), 32'(lvl[b]));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
        if (m_valid) begin
            chk("evt_id", 32'(evt_id), 32'(m_id));
            chk("evt_type", 32'(evt_type), 32'(m_type));
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_id", 32'(evt_id), 32'd0);
        chk("rst_type", 32'(evt_type), 32'd0);
        chk("rst_ovr", 32'(evt_overrun), 32'd0);
    endtask

    initial begin
        int n_long, n_rep;
        bit saw_ovr;
        model_reset();

        // Power-on reset.
        repeat (3) step();
        chk("por_valid", 32'(evt_valid), 32'd0);
        chk("por_id", 32'(evt_id), 32'd0);
        chk("por_level", 32'(btn_level), 32'd0);
        rst_n = 1'b1;
        step();

        // Bounce, then a clean press of btn0.
        btn_sync = 4'b0001; repeat (3) step();
        btn_sync = 4'b0000; step();
        btn_sync = 4'b0001; repeat (4) step();
        chk("bounce_level", 32'(btn_level[0]), 32'd0);
        chk("bounce_quiet", 32'(evt_valid), 32'd0);
        step();
        chk("press_level", 32'(btn_level[0]), 32'd1);
        step();
        chk("press_valid", 32'(evt_valid), 32'd1);
        chk("press_id", 32'(evt_id), 32'd0);
        chk("press_type", 32'(evt_type), 32'd0);

        // Long hold of btn0: LONG once, REPEATs only with auto-repeat.
        n_long = 0; n_rep = 0;
        repeat (45) begin
            step();
            if (evt_valid && evt_type == 2'd2) n_long++;
            if (evt_valid && evt_type == 2'd3) n_rep++;
        end
        chk("long_count", 32'(n_long), 32'd1);
        chk("repeat_count", 32'(n_rep), REP_EN ? 32'd3 : 32'd0);
        btn_sync = 4'b0000; repeat (10) step();

        // btn2 press/release while the consumer stalls.
        evt_ready = 1'b0;
        btn_sync = 4'b0100; repeat (10) step();
        btn_sync = 4'b0000; repeat (30) step();
        chk("stall_valid", 32'(evt_valid), 32'd1);
        chk("stall_id", 32'(evt_id), 32'd2);
        chk("stall_type", 32'(evt_type), 32'd0);
        evt_ready = 1'b1; step();
        chk("after_id", 32'(evt_id), 32'd2);
        chk("after_type", 32'(evt_type), 32'd1);
        repeat (3) step();

        // btn1 and btn3 together: lowest index first, back-to-back.
        btn_sync = 4'b1010; repeat (5) step();
        step();
        chk("pair_first", 32'(evt_id), 32'd1);
        step();
        chk("pair_second", 32'(evt_id), 32'd3);
        chk("pair_valid", 32'(evt_valid), 32'd1);
        btn_sync = 4'b0000; repeat (10) step();

        // Overrun: two press/release pairs while stalled.
        evt_ready = 1'b0; saw_ovr = 0;
        repeat (2) begin
            btn_sync = 4'b0001; repeat (6) begin step(); saw_ovr |= evt_overrun; end
            btn_sync = 4'b0000; repeat (6) begin step(); saw_ovr |= evt_overrun; end
        end
        chk("overrun_seen", 32'(saw_ovr), 32'd1);
        evt_ready = 1'b1; repeat (6) step();

        // Reset during PRESS_WAIT.
        btn_sync = 4'b0001; repeat (3) step();
        reset_now();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("fresh_wait", 32'(btn_level[0]), 32'd0);
        step();
        chk("fresh_press", 32'(btn_level[0]), 32'd1);
        btn_sync = 4'b0000; repeat (8) step();

        // Reset during DOWN.
        btn_sync = 4'b0010; repeat (9) step();
        reset_now();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("post_rst_quiet", 32'(evt_valid), 32'd0);
        btn_sync = 4'b0000; repeat (6) step();

        // Random buttons and ready.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 15) == 0) btn_sync[b] = ~btn_sync[b];
            evt_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        // Slow buttons, mostly stalled consumer.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 47) == 0) btn_sync[b] = ~btn_sync[b];
            evt_ready = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
